spi_cmd_sequencer: RTL and testbench

Command queue and sequencer that sits directly upstream of the SPI driver. It accepts register-access commands from the AXI/IPIF register block, buffers them in a FIFO, and issues them one at a time to the SPI driver as a clean, registered new_command strobe with stable address and data. It times each transfer with its own bit counter, because the driver has no busy/done output. At the end of each transfer it captures the driver's readback data for the host.

---
 rtl/spi_cmd_sequencer_pkg.sv | 28 ++
 rtl/spi_cmd_sequencer_if.sv | 35 +++
 rtl/spi_cmd_sequencer_fifo.sv | 47 ++++
 rtl/spi_cmd_sequencer.sv | 124 ++++++++++++
 tb/tb_spi_cmd_sequencer.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/spi_cmd_sequencer_pkg.sv
// spi_cmd_pkg: shared widths, command record, FSM states and transfer timing
package spi_cmd_pkg;

    localparam int REG_WIDTH    = 8;
    localparam int MSG_LEN      = 2;
    localparam int DATA_W       = REG_WIDTH * (MSG_LEN - 1);
    localparam int FIFO_DEPTH   = 8;
    localparam int GUARD_CYCLES = 4;
    localparam int ADDR_W       = $clog2(FIFO_DEPTH);
    localparam int LEVEL_W      = $clog2(FIFO_DEPTH + 1);

    // The driver gives no done indication, so a transfer is timed as
    // one clock per shifted bit plus a settling guard before readback.
    function automatic int transfer_cycles(input int reg_width, input int msg_len, input int guard);
        return reg_width * msg_len + guard;
    endfunction

    localparam int TRANSFER_CYCLES = transfer_cycles(REG_WIDTH, MSG_LEN, GUARD_CYCLES);
    localparam int CNT_W           = $clog2(TRANSFER_CYCLES);

    typedef struct packed {
        logic [REG_WIDTH-1:0] addr;
        logic [DATA_W-1:0]    data;
    } spi_cmd_t;

    typedef enum logic [2:0] {IDLE, LOAD, STROBE, WAIT, CAPTURE} seq_state_e;

endpackage

// File: rtl/spi_cmd_sequencer_if.sv
// spi_cmd_sequencer_if: host command/readback port and SPI driver port bundle
interface spi_cmd_sequencer_if;
    import spi_cmd_pkg::*;

    logic                 host_wr_en;
    logic [REG_WIDTH-1:0] host_addr;
    logic [DATA_W-1:0]    host_data;
    logic                 host_full;
    logic [LEVEL_W-1:0]   host_level;
    logic                 busy;
    logic                 rd_valid;
    logic [REG_WIDTH-1:0] rd_addr;
    logic [DATA_W-1:0]    rd_data;
    logic                 rd_ack;
    logic                 err_overflow;
    logic                 err_rd_overrun;
    logic                 err_clear;
    logic                 spi_new_command;
    logic [REG_WIDTH-1:0] spi_register_addr;
    logic [DATA_W-1:0]    spi_write_data;
    logic [DATA_W-1:0]    spi_read_data;

    modport slave (
        input  host_wr_en, host_addr, host_data, rd_ack, err_clear, spi_read_data,
        output host_full, host_level, busy, rd_valid, rd_addr, rd_data,
               err_overflow, err_rd_overrun, spi_new_command, spi_register_addr, spi_write_data
    );

    modport master (
        output host_wr_en, host_addr, host_data, rd_ack, err_clear, spi_read_data,
        input  host_full, host_level, busy, rd_valid, rd_addr, rd_data,
               err_overflow, err_rd_overrun, spi_new_command, spi_register_addr, spi_write_data
    );

endinterface

// File: rtl/spi_cmd_sequencer_fifo.sv
// spi_cmd_fifo: synchronous command FIFO; a push into a full FIFO is accepted when a pop frees a slot in the same cycle
module spi_cmd_fifo
    import spi_cmd_pkg::*;
(
    input  logic               clk,
    input  logic               rstn,
    input  logic               push,
    input  logic               pop,
    input  spi_cmd_t           din,
    output spi_cmd_t           dout,
    output logic               full,
    output logic               empty,
    output logic               drop,
    output logic [LEVEL_W-1:0] level
);

    spi_cmd_t          mem [FIFO_DEPTH];
    logic [ADDR_W:0]   wr_ptr;
    logic [ADDR_W:0]   rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign level   = wr_ptr - rd_ptr;
    assign full    = level == LEVEL_W'(FIFO_DEPTH);
    assign empty   = wr_ptr == rd_ptr;
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign drop    = push & ~do_push;
    assign dout    = mem[rd_ptr[ADDR_W-1:0]];

    // Pointer advance; the extra MSB distinguishes full from empty.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            wr_ptr <= wr_ptr + (ADDR_W+1)'(do_push);
            rd_ptr <= rd_ptr + (ADDR_W+1)'(do_pop);
        end
    end

    // Storage is not reset; occupancy is tracked by the pointers alone.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[ADDR_W-1:0]] <= din;
    end

endmodule

// File: rtl/spi_cmd_sequencer.sv
// spi_cmd_sequencer: queues host register commands and issues them one at a time to the SPI driver, capturing readback
module spi_cmd_sequencer
    import spi_cmd_pkg::*;
(
    input logic                 clk,
    input logic                 rstn,
    spi_cmd_sequencer_if.slave  bus
);

    seq_state_e           state;
    seq_state_e           state_nx;
    logic [CNT_W-1:0]     cnt;
    logic                 pop;
    logic                 empty;
    logic                 full;
    logic                 drop;
    logic                 overrun;
    logic [LEVEL_W-1:0]   level;
    spi_cmd_t             head;
    logic                 new_command;
    logic [REG_WIDTH-1:0] reg_addr;
    logic [DATA_W-1:0]    write_data;
    logic                 rd_valid;
    logic [REG_WIDTH-1:0] rd_addr;
    logic [DATA_W-1:0]    rd_data;
    logic                 err_overflow;
    logic                 err_rd_overrun;

    spi_cmd_fifo u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (bus.host_wr_en),
        .pop   (pop),
        .din   ('{addr: bus.host_addr, data: bus.host_data}),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .drop  (drop),
        .level (level)
    );

    assign pop     = (state == IDLE) & ~empty;
    assign overrun = (state == CAPTURE) & rd_valid & ~bus.rd_ack;

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nx;
    end

    // Next-state: one command walks IDLE->LOAD->STROBE->WAIT->CAPTURE->IDLE.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = empty ? IDLE : LOAD;
            LOAD:    state_nx = STROBE;
            STROBE:  state_nx = WAIT;
            WAIT:    state_nx = (cnt == '0) ? CAPTURE : WAIT;
            CAPTURE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Transfer timer: armed on the strobe, counts down through WAIT.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)                cnt <= '0;
        else if (state == STROBE) cnt <= CNT_W'(TRANSFER_CYCLES - 1);
        else if (state == WAIT)   cnt <= cnt - 1'b1;
    end

    // Driver-facing registers: address/data settle during LOAD, strobe follows one cycle later.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            reg_addr    <= '0;
            write_data  <= '0;
            new_command <= 1'b0;
        end else begin
            if (pop) begin
                reg_addr   <= head.addr;
                write_data <= head.data;
            end
            new_command <= state == LOAD;
        end
    end

    // Readback register: a capture always wins over a coincident acknowledge.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_valid <= 1'b0;
            rd_addr  <= '0;
            rd_data  <= '0;
        end else if (state == CAPTURE) begin
            rd_valid <= 1'b1;
            rd_addr  <= reg_addr;
            rd_data  <= bus.spi_read_data;
        end else if (bus.rd_ack) begin
            rd_valid <= 1'b0;
        end
    end

    // Sticky error flags; a new event outranks a coincident clear.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            err_overflow   <= 1'b0;
            err_rd_overrun <= 1'b0;
        end else begin
            err_overflow   <= drop | (err_overflow & ~bus.err_clear);
            err_rd_overrun <= overrun | (err_rd_overrun & ~bus.err_clear);
        end
    end

    assign bus.host_full         = full;
    assign bus.host_level        = level;
    assign bus.busy              = (level != '0) | (state != IDLE);
    assign bus.rd_valid          = rd_valid;
    assign bus.rd_addr           = rd_addr;
    assign bus.rd_data           = rd_data;
    assign bus.err_overflow      = err_overflow;
    assign bus.err_rd_overrun    = err_rd_overrun;
    assign bus.spi_new_command   = new_command;
    assign bus.spi_register_addr = reg_addr;
    assign bus.spi_write_data    = write_data;

endmodule

// File: tb/tb_spi_cmd_sequencer.sv
// tb_spi_cmd_sequencer: directed and randomized stimulus checked against a transaction-schedule model
module tb_spi_cmd_sequencer;
    import spi_cmd_pkg::*;

    logic clk;
    logic rstn;
    spi_cmd_sequencer_if bus();

    spi_cmd_sequencer dut (.clk(clk), .rstn(rstn), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests;
    int n_fail;
    int cyc;
    int free_at;
    int strobe_at;
    int cap_at;
    int e_level, e_full, e_busy, e_nc, e_addr, e_data, e_rv, e_ra, e_rd, e_ovf, e_ovr;
    spi_cmd_t q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        q.delete();
        free_at = 0;
        strobe_at = -1;
        cap_at = -1;
        {e_level, e_full, e_busy, e_nc, e_addr, e_data} = '0;
        {e_rv, e_ra, e_rd, e_ovf, e_ovr} = '0;
    endtask

    // Each popped command is scheduled by arithmetic: strobe two cycles later,
    // capture TRANSFER_CYCLES after that, next pop possible the cycle after capture.
    task automatic model_step(input logic wr, input logic [REG_WIDTH-1:0] a, input logic [DATA_W-1:0] d,
                              input logic ack, input logic clr, input logic [DATA_W-1:0] rdat);
        spi_cmd_t c;
        bit ovf = 0;
        bit ovr = 0;
        if (cyc >= free_at && q.size() > 0) begin
            c = q.pop_front();
            e_addr = int'(c.addr);
            e_data = int'(c.data);
            strobe_at = cyc + 2;
            cap_at = cyc + 3 + TRANSFER_CYCLES;
            free_at = cyc + 4 + TRANSFER_CYCLES;
        end
        if (cyc == cap_at) begin
            ovr = e_rv == 1 && !ack;
            e_rv = 1;
            e_ra = e_addr;
            e_rd = int'(rdat);
        end else if (ack) begin
            e_rv = 0;
        end
        if (wr) begin
            if (q.size() < FIFO_DEPTH) q.push_back('{addr: a, data: d});
            else ovf = 1;
        end
        e_ovf = (ovf || (e_ovf == 1 && !clr)) ? 1 : 0;
        e_ovr = (ovr || (e_ovr == 1 && !clr)) ? 1 : 0;
        cyc++;
        e_level = q.size();
        e_full = (q.size() == FIFO_DEPTH) ? 1 : 0;
        e_busy = (q.size() != 0 || cyc < free_at) ? 1 : 0;
        e_nc = (cyc == strobe_at) ? 1 : 0;
    endtask

    task automatic check_all();
        check("level", 32'(bus.host_level), e_level);
        check("full", 32'(bus.host_full), e_full);
        check("busy", 32'(bus.busy), e_busy);
        check("new_command", 32'(bus.spi_new_command), e_nc);
        check("spi_addr", 32'(bus.spi_register_addr), e_addr);
        check("spi_data", 32'(bus.spi_write_data), e_data);
        check("rd_valid", 32'(bus.rd_valid), e_rv);
        check("rd_addr", 32'(bus.rd_addr), e_ra);
        check("rd_data", 32'(bus.rd_data), e_rd);
        check("err_overflow", 32'(bus.err_overflow), e_ovf);
        check("err_rd_overrun", 32'(bus.err_rd_overrun), e_ovr);
    endtask

    task automatic step(input logic wr, input logic [REG_WIDTH-1:0] a, input logic [DATA_W-1:0] d,
                        input logic ack, input logic clr, input logic [DATA_W-1:0] rdat);
        @(negedge clk);
        check_all();
        bus.host_wr_en = wr;
        bus.host_addr = a;
        bus.host_data = d;
        bus.rd_ack = ack;
        bus.err_clear = clr;
        bus.spi_read_data = rdat;
        model_step(wr, a, d, ack, clr, rdat);
        @(posedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, 1'b0, DATA_W'($urandom));
    endtask

    task automatic drive_zero();
        bus.host_wr_en = 1'b0;
        bus.host_addr = '0;
        bus.host_data = '0;
        bus.rd_ack = 1'b0;
        bus.err_clear = 1'b0;
        bus.spi_read_data = '0;
    endtask

    initial begin
        int n;
        n_tests = 0;
        n_fail = 0;
        cyc = 0;
        rstn = 1'b0;
        drive_zero();
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        idle(3);

        // Reset in the middle of a transfer aborts it with no capture.
        step(1'b1, 8'h12, 8'h77, 1'b0, 1'b0, 8'h00);
        idle(10);
        @(negedge clk);
        rstn = 1'b0;
        drive_zero();
        #1;
        check("rst_level", 32'(bus.host_level), 0);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_new_command", 32'(bus.spi_new_command), 0);
        check("rst_spi_addr", 32'(bus.spi_register_addr), 0);
        check("rst_rd_valid", 32'(bus.rd_valid), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        model_reset();
        idle(30);

        // Single transfer timing.
        step(1'b1, 8'hA5, 8'h3C, 1'b0, 1'b0, 8'h5A);
        for (int i = 0; i < 24; i++) step(1'b0, '0, '0, 1'b0, 1'b0, 8'h5A);
        #1;
        check("single_rd_valid", 32'(bus.rd_valid), 1);
        check("single_rd_addr", 32'(bus.rd_addr), 32'hA5);
        check("single_rd_data", 32'(bus.rd_data), 32'h5A);
        idle(3);

        // Nine back-to-back pushes fill the FIFO; a tenth is dropped.
        for (int i = 1; i <= 9; i++) step(1'b1, REG_WIDTH'(i), DATA_W'($urandom), 1'b0, 1'b0, DATA_W'($urandom));
        #1;
        check("fill_level", 32'(bus.host_level), 8);
        check("fill_full", 32'(bus.host_full), 1);
        check("fill_no_ovf", 32'(bus.err_overflow), 0);
        step(1'b1, 8'hEE, 8'hEE, 1'b0, 1'b0, DATA_W'($urandom));
        #1;
        check("drop_ovf", 32'(bus.err_overflow), 1);
        step(1'b0, '0, '0, 1'b0, 1'b1, DATA_W'($urandom));
        #1;
        check("clear_ovf", 32'(bus.err_overflow), 0);

        // Push while full in the very cycle the sequencer pops.
        n = 0;
        while (!(cyc >= free_at && q.size() == FIFO_DEPTH) && n < 100) begin
            idle(1);
            n++;
        end
        check("sync_full_pop_reached", 32'(n < 100), 1);
        step(1'b1, 8'h0A, 8'hA0, 1'b0, 1'b0, DATA_W'($urandom));
        #1;
        check("full_pop_level", 32'(bus.host_level), 8);
        check("full_pop_no_ovf", 32'(bus.err_overflow), 0);

        // Unacknowledged captures overwrite and flag overrun.
        idle(3 * (TRANSFER_CYCLES + 4));
        #1;
        check("overrun_set", 32'(bus.err_rd_overrun), 1);
        step(1'b0, '0, '0, 1'b0, 1'b1, DATA_W'($urandom));

        // Acknowledge in the capture cycle: new data stays valid, no overrun.
        n = 0;
        while (cyc != cap_at && n < 100) begin
            idle(1);
            n++;
        end
        check("cap_ack_reached", 32'(n < 100), 1);
        step(1'b0, '0, '0, 1'b1, 1'b0, 8'hC3);
        #1;
        check("cap_ack_rd_valid", 32'(bus.rd_valid), 1);
        check("cap_ack_rd_data", 32'(bus.rd_data), 32'hC3);
        check("cap_ack_no_overrun", 32'(bus.err_rd_overrun), 0);

        // Randomized traffic at several push rates.
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < 1000; i++) begin
                logic wr;
                wr = (p == 0) ? ($urandom_range(0, 29) == 0) : (p == 1) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 11) == 0);
                step(wr, REG_WIDTH'($urandom), DATA_W'($urandom), $urandom_range(0, 3) == 0,
                     $urandom_range(0, 49) == 0, DATA_W'($urandom));
            end
        end
        idle(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
